// File: rtl/bsg_round_robin_merge_fifo.sv
// Round-robin N-to-1 merge into a 2-entry output FIFO.
// Each cycle the FIFO has room, the first valid channel after the last winner
// is dequeued through yumi_o. Its data and channel index are written into the
// FIFO, which presents a valid/ready head to the consumer.
module bsg_round_robin_merge_fifo #(
    parameter int inputs_p = 4,
    parameter int width_p  = 8,
    localparam int tag_w   = (inputs_p > 1) ? $clog2(inputs_p) : 1
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [inputs_p-1:0]         v_i,
    input  logic [inputs_p*width_p-1:0] data_i,
    output logic [inputs_p-1:0]         yumi_o,
    output logic                        v_o,
    output logic [width_p-1:0]          data_o,
    output logic [tag_w-1:0]            tag_o,
    input  logic                        ready_i
);

    logic [width_p-1:0] data_mem [2];
    logic [tag_w-1:0]   tag_mem  [2];
    logic               wptr_r;
    logic               rptr_r;
    logic [1:0]         count_r;
    logic [tag_w-1:0]   last_r;

    logic               grant_v;
    logic [tag_w-1:0]   grant_idx;
    logic [tag_w-1:0]   cand_idx;
    logic               can_enq;
    logic               do_enq;
    logic               do_deq;

    assign can_enq = (count_r != 2'd2);
    // Reset blocks the grant so that no producer loses an item while state is cleared.
    assign do_enq  = ~reset_i & can_enq & grant_v;
    assign v_o     = (count_r != 2'd0);
    assign do_deq  = v_o & ready_i;
    assign data_o  = data_mem[rptr_r];
    assign tag_o   = tag_mem[rptr_r];

    // Search from the channel after the last winner, wrapping; the first hit wins.
    always_comb begin
        grant_v   = 1'b0;
        grant_idx = '0;
        cand_idx  = '0;
        for (int i = 1; i <= inputs_p; i++) begin
            cand_idx = tag_w'((int'(last_r) + i) % inputs_p);
            if (!grant_v && v_i[cand_idx]) begin
                grant_v   = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    // The dequeue strobe is the one-hot grant, issued only when the item is actually taken.
    always_comb begin
        yumi_o = '0;
        if (do_enq) begin
            yumi_o = inputs_p'(1) << grant_idx;
        end
    end

    // FIFO storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk_i) begin
        if (do_enq) begin
            data_mem[wptr_r] <= data_i[grant_idx*width_p +: width_p];
            tag_mem[wptr_r]  <= grant_idx;
        end
    end

    // Pointers, occupancy and arbitration priority.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_r  <= 1'b0;
            rptr_r  <= 1'b0;
            count_r <= 2'd0;
            last_r  <= tag_w'(inputs_p - 1);
        end else begin
            if (do_enq) begin
                wptr_r <= ~wptr_r;
                last_r <= grant_idx;
            end
            if (do_deq) begin
                rptr_r <= ~rptr_r;
            end
            case ({do_enq, do_deq})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_bsg_round_robin_merge_fifo.sv
// Directed vector bench for the round-robin merge FIFO (4 channels, 8-bit data).
module tb_bsg_round_robin_merge_fifo;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset_i;
    logic [N-1:0]   v_i;
    logic [N*W-1:0] data_i;
    logic [N-1:0]   yumi_o;
    logic           v_o;
    logic [W-1:0]   data_o;
    logic [1:0]     tag_o;
    logic           ready_i;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic [3:0] v;
        logic       rdy;
        logic [3:0] yumi;
        logic       vo;
        logic [1:0] tag;
    } vec_t;

    vec_t vecs[$];

    bsg_round_robin_merge_fifo #(.inputs_p(N), .width_p(W)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .v_i     (v_i),
        .data_i  (data_i),
        .yumi_o  (yumi_o),
        .v_o     (v_o),
        .data_o  (data_o),
        .tag_o   (tag_o),
        .ready_i (ready_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [3:0] v, input logic rdy,
                       input logic [3:0] yumi, input logic vo, input logic [1:0] tag);
        vec_t e;
        e.rst = rst; e.v = v; e.rdy = rdy; e.yumi = yumi; e.vo = vo; e.tag = tag;
        vecs.push_back(e);
    endtask

    // One cycle: drive at negedge, check shortly after; data is expected to be 8'h10 + tag.
    task automatic step(input string name, input logic rst, input logic [3:0] v, input logic rdy,
                        input logic [3:0] eyumi, input logic evo, input logic [1:0] etag);
        @(negedge clk);
        reset_i = rst;
        v_i     = v;
        ready_i = rdy;
        #1;
        chk({name, " yumi"}, 32'(yumi_o), 32'(eyumi));
        chk({name, " v_o"}, 32'(v_o), 32'(evo));
        if (evo) begin
            chk({name, " tag"}, 32'(tag_o), 32'(etag));
            chk({name, " data"}, 32'(data_o), 32'(8'h10 + 8'(etag)));
        end
    endtask

    // Invariants sampled every cycle once reset has settled.
    logic           mon_en = 1'b0;
    logic           p_v, p_rdy, p_rst;
    logic [W-1:0]   p_data;
    logic [1:0]     p_tag;
    logic [3:0]     fair_cnt [N];

    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            if (!$onehot0(yumi_o)) begin
                checks++; errors++;
                $display("FAIL yumi_onehot0: got %b expected one-hot or zero", yumi_o);
            end
            if ((yumi_o & ~v_i) != '0) begin
                checks++; errors++;
                $display("FAIL yumi_implies_v: got yumi %b with v_i %b", yumi_o, v_i);
            end
            if (p_v && !p_rdy && !p_rst) begin
                chk("hold v_o", 32'(v_o), 32'd1);
                chk("hold data", 32'(data_o), 32'(p_data));
                chk("hold tag", 32'(tag_o), 32'(p_tag));
            end
        end
        p_v = v_o; p_rdy = ready_i; p_rst = reset_i; p_data = data_o; p_tag = tag_o;
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            data_i[k*W +: W] = 8'h10 + 8'(k);
            fair_cnt[k] = '0;
        end
        reset_i = 1'b1; v_i = 4'b1111; ready_i = 1'b1;

        // reset hold
        for (int k = 0; k < 5; k++) add(1, 4'b1111, 1, 4'b0000, 0, 0);
        // streaming fairness: grants 0,1,2,3,0,1,2,3, head lags by one cycle
        add(0, 4'b1111, 1, 4'b0001, 0, 0);
        add(0, 4'b1111, 1, 4'b0010, 1, 0);
        add(0, 4'b1111, 1, 4'b0100, 1, 1);
        add(0, 4'b1111, 1, 4'b1000, 1, 2);
        add(0, 4'b1111, 1, 4'b0001, 1, 3);
        add(0, 4'b1111, 1, 4'b0010, 1, 0);
        add(0, 4'b1111, 1, 4'b0100, 1, 1);
        add(0, 4'b1111, 1, 4'b1000, 1, 2);
        add(0, 4'b0000, 1, 4'b0000, 1, 3);
        add(0, 4'b0000, 0, 4'b0000, 0, 0);
        // backpressure: fill, stall, single ready pulse
        add(0, 4'b1111, 0, 4'b0001, 0, 0);
        add(0, 4'b1111, 0, 4'b0010, 1, 0);
        add(0, 4'b1111, 0, 4'b0000, 1, 0);
        add(0, 4'b1111, 1, 4'b0000, 1, 0);
        add(0, 4'b1111, 0, 4'b0100, 1, 1);
        add(0, 4'b0000, 1, 4'b0000, 1, 1);
        add(0, 4'b0000, 1, 4'b0000, 1, 2);
        add(0, 4'b0000, 0, 4'b0000, 0, 0);
        // sparse requests 0101 (last winner was 2)
        add(0, 4'b0101, 1, 4'b0001, 0, 0);
        add(0, 4'b0101, 1, 4'b0100, 1, 0);
        add(0, 4'b0101, 1, 4'b0001, 1, 2);
        add(0, 4'b0101, 1, 4'b0100, 1, 0);
        add(0, 4'b0101, 1, 4'b0001, 1, 2);
        add(0, 4'b0101, 1, 4'b0100, 1, 0);
        add(0, 4'b0000, 1, 4'b0000, 1, 2);
        // wrap and sole requester
        add(0, 4'b1000, 1, 4'b1000, 0, 0);
        add(0, 4'b1000, 1, 4'b1000, 1, 3);
        add(0, 4'b1001, 1, 4'b0001, 1, 3);
        add(0, 4'b1001, 1, 4'b1000, 1, 0);
        add(0, 4'b0000, 1, 4'b0000, 1, 3);
        // reset mid-operation with a full FIFO
        add(0, 4'b1111, 0, 4'b0001, 0, 0);
        add(0, 4'b1111, 0, 4'b0010, 1, 0);
        add(1, 4'b1111, 0, 4'b0000, 1, 0);
        add(0, 4'b1010, 0, 4'b0010, 0, 0);
        add(0, 4'b0000, 1, 4'b0000, 1, 1);
        add(0, 4'b0000, 0, 4'b0000, 0, 0);

        @(posedge clk);
        mon_en = 1'b1;

        foreach (vecs[i]) begin
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].v, vecs[i].rdy,
                 vecs[i].yumi, vecs[i].vo, vecs[i].tag);
            if (i >= 5 && i <= 12) begin
                for (int k = 0; k < N; k++) if (yumi_o[k]) fair_cnt[k]++;
            end
        end
        for (int k = 0; k < N; k++) chk($sformatf("fair ch%0d", k), 32'(fair_cnt[k]), 32'd2);

        // full FIFO ignores changing requests, head stays put (last winner was 1)
        step("bp0", 0, 4'b1111, 0, 4'b0100, 0, 0);
        step("bp1", 0, 4'b1111, 0, 4'b1000, 1, 2);
        step("bp2", 0, 4'b0011, 0, 4'b0000, 1, 2);
        step("bp3", 0, 4'b0101, 1, 4'b0000, 1, 2);
        step("bp4", 0, 4'b0000, 1, 4'b0000, 1, 3);
        step("bp5", 0, 4'b0000, 0, 4'b0000, 0, 0);

        // full-throughput from a single channel pair after wrap (last winner was 3)
        step("tp0", 0, 4'b0110, 1, 4'b0010, 0, 0);
        step("tp1", 0, 4'b0110, 1, 4'b0100, 1, 1);
        step("tp2", 0, 4'b0110, 1, 4'b0010, 1, 2);
        step("tp3", 0, 4'b0000, 1, 4'b0000, 1, 1);
        step("tp4", 0, 4'b0000, 1, 4'b0000, 0, 0);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bsg_round_robin_merge_fifo.md
Name: bsg_round_robin_merge_fifo

Overview:
- N-to-1 merge stage directly downstream of N producer channels.
- Round-robin arbitrates among valid inputs and dequeues the winner via valid/yumi.
- Winner's data and source index are pushed into a 2-entry output FIFO, which presents a valid/ready interface to the consumer.
- Provides the fairness of a round-robin arbiter with registered, back-pressurable output for network/cache request merging.

Parameters:
- inputs_p, 4, number of input channels (>=1)
- width_p, 8, data width per channel
- tag width: tag_w = BSG_SAFE_CLOG2(inputs_p), derived, not overridable

Ports:
- clk_i  in  1  clock; all state updates on posedge
- reset_i  in  1  synchronous, active-high reset
- v_i  in  inputs_p  per-channel valid
- data_i  in  inputs_p*width_p  channel k occupies bits [k*width_p +: width_p]
- yumi_o  out  inputs_p  one-hot (or zero) dequeue of the granted channel, same cycle
- v_o  out  1  output FIFO head valid
- data_o  out  width_p  head data
- tag_o  out  tag_w  head source channel index
- ready_i  in  1  consumer accepts head when v_o & ready_i

Behaviour:
State:
- 2-entry FIFO: storage, read/write pointers, count 0..2.
- last_r: index of the last granted channel, tag_w bits.

Reset (reset_i high at posedge):
- count=0, pointers=0, last_r=inputs_p-1, so channel 0 has first priority.
- While reset_i is high, yumi_o=0 combinationally, regardless of v_i.
- v_o=0 the cycle after reset is sampled.
- data_o/tag_o are don't-care while v_o=0.

Enqueue:
- can_enq = (count != 2).
- When can_enq and |v_i, the grant is the first valid channel searching last_r+1, last_r+2, ... modulo inputs_p, wrapping.
- yumi_o = onehot(grant); otherwise yumi_o = 0.
- Granted data_i slice and grant index are written at posedge; last_r <= grant.
- last_r is unchanged on cycles with no grant.

Dequeue:
- When v_o & ready_i: read pointer advances and count decrements at posedge.
- v_o = (count != 0). No combinational path from v_i to v_o; latency from yumi_o to v_o is 1 cycle.

Simultaneous events:
- Enqueue and dequeue in the same cycle with count=1: count stays 1, FIFO order preserved.
- Full throughput of one item per cycle when ready_i is held high.
- count=2: no grant even if ready_i=1 this cycle. No bypass, so yumi_o never depends on ready_i.

Ordering and fairness:
- Output order equals grant order.
- Over any window of inputs_p*k grant cycles with fixed v_i of popcount P, each requesting channel is granted floor or ceil of (inputs_p*k)/P times.
- Non-requesting channels are never granted.

Edge cases:
- inputs_p=1: tag_o is 1 bit and always 0; yumi_o = v_i & can_enq.
- Wrap: grant at channel inputs_p-1 followed by a search that wraps to 0.
- Reset mid-operation: buffered items are discarded, not emitted; priority restarts at channel 0.

Invariants (bench asserts every cycle):
- yumi_o is one-hot0.
- yumi_o[k] implies v_i[k].
- count <= 2.
- v_o is stable until ready_i once asserted; data_o and tag_o are stable while v_o & ~ready_i.

Test Plan:
All scenarios use inputs_p=4, width_p=8, data_i[k] = 8'h10+k.
1. Reset hold: reset_i=1 for 5 cycles with v_i=4'b1111 -> yumi_o=0 and v_o=0 throughout. First cycle after reset: yumi_o=4'b0001, then v_o=1 with tag_o=0, data_o=8'h10.
2. Streaming fairness: v_i=4'b1111, ready_i=1 for 8 cycles -> yumi_o sequence 0001,0010,0100,1000,0001,0010,0100,1000. tag_o sequence 0,1,2,3,0,1,2,3 starting one cycle later. Each channel granted exactly 2 times.
3. Backpressure: v_i=4'b1111, ready_i=0 -> grants to channels 0 and 1, then yumi_o=0 with v_o held at tag 0. Pulse ready_i for one cycle -> tag 0 leaves; next cycle yumi_o=4'b0100 and head becomes tag 1.
4. Sparse requests: v_i=4'b0101, ready_i=1 for 6 cycles -> grants 0,2,0,2,0,2; tags 1 and 3 never appear.
5. Wrap and sole requester: after a grant to channel 3, set v_i=4'b1000 -> channel 3 granted again. Then v_i=4'b1001 -> channel 0 next, then 3.
6. Reset mid-operation: FIFO full (count=2, ready_i=0), assert reset_i one cycle -> v_o=0 next cycle and no stale tag emitted. With v_i=4'b1010 the first grant is channel 1.
